// File: rtl/priority_encoder.sv
// Eight-input priority encoder, p7 highest. Drives a 3-bit index plus a valid flag.
// The outputs are registered (one-cycle latency) or purely combinational, selected by OUT_REG.
module priority_encoder #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic p0,
    input  logic p1,
    input  logic p2,
    input  logic p3,
    input  logic p4,
    input  logic p5,
    input  logic p6,
    input  logic p7,
    output logic z0,
    output logic z1,
    output logic z2,
    output logic v
);

    logic [2:0] enc_index;
    logic       enc_valid;

    // The chain tests from p7 downward. The first high line decides the result,
    // so an unknown value on any lower line is never examined.
    always_comb begin
        enc_index = 3'd0;
        enc_valid = 1'b1;
        if (p7 == 1'b1)      enc_index = 3'd7;
        else if (p6 == 1'b1) enc_index = 3'd6;
        else if (p5 == 1'b1) enc_index = 3'd5;
        else if (p4 == 1'b1) enc_index = 3'd4;
        else if (p3 == 1'b1) enc_index = 3'd3;
        else if (p2 == 1'b1) enc_index = 3'd2;
        else if (p1 == 1'b1) enc_index = 3'd1;
        else if (p0 == 1'b1) enc_index = 3'd0;
        else                 enc_valid = 1'b0;
    end

    generate
        if (OUT_REG) begin : g_registered
            logic [2:0] index_q;
            logic       valid_q;

            // The asynchronous reset clears the outputs at once, and the value that was
            // in flight is dropped. After release, the next edge loads a fresh sample.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    index_q <= 3'd0;
                    valid_q <= 1'b0;
                end else begin
                    index_q <= enc_index;
                    valid_q <= enc_valid;
                end
            end

            assign {z2, z1, z0} = index_q;
            assign v            = valid_q;
        end else begin : g_combinational
            wire unused_clk_rst = clk ^ rst;

            assign {z2, z1, z0} = enc_index;
            assign v            = enc_valid;
        end
    endgenerate

endmodule

// File: tb/tb_priority_encoder.sv
// Directed bench for priority_encoder. It drives a registered instance and a combinational
// instance from the same request vector and checks both against hand-computed values.
module tb_priority_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] z_reg;
    logic       v_reg;
    logic [2:0] z_cmb;
    logic       v_cmb;
    int         errors;
    int         checks;

    priority_encoder #(.OUT_REG(1'b1)) dut_reg (
        .clk(clk), .rst(rst),
        .p0(req[0]), .p1(req[1]), .p2(req[2]), .p3(req[3]),
        .p4(req[4]), .p5(req[5]), .p6(req[6]), .p7(req[7]),
        .z0(z_reg[0]), .z1(z_reg[1]), .z2(z_reg[2]), .v(v_reg)
    );

    priority_encoder #(.OUT_REG(1'b0)) dut_cmb (
        .clk(clk), .rst(rst),
        .p0(req[0]), .p1(req[1]), .p2(req[2]), .p3(req[3]),
        .p4(req[4]), .p5(req[5]), .p6(req[6]), .p7(req[7]),
        .z0(z_cmb[0]), .z1(z_cmb[1]), .z2(z_cmb[2]), .v(v_cmb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares the index and the valid flag together. A mismatch in either one is counted once.
    task automatic check_output(input string tag, input logic [2:0] obs_z, input logic obs_v,
                                input logic [2:0] exp_z, input logic exp_v);
        checks++;
        assert ({obs_z, obs_v} === {exp_z, exp_v})
        else begin
            errors++;
            $error("[TB] FAIL %s: observed z=%b v=%b, expected z=%b v=%b",
                   tag, obs_z, obs_v, exp_z, exp_v);
        end
    endtask

    // Inputs change on the falling edge, well away from the sampling edge.
    task automatic apply_stimulus(input logic [7:0] vec);
        @(negedge clk);
        req = vec;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] exp_z;
        logic       exp_v;
        errors = 0;
        checks = 0;

        // Power-up reset: the outputs must clear without any clock edge.
        rst = 1'b1;
        req = 8'b1010_0101;
        #2;
        check_output("por_reg", z_reg, v_reg, 3'b000, 1'b0);
        check_output("por_cmb_ignores_rst", z_cmb, v_cmb, 3'b111, 1'b1);

        apply_stimulus(8'b0010_0000);
        rst = 1'b0;
        #1;
        check_output("p5_before_edge", z_reg, v_reg, 3'b000, 1'b0);
        step();
        check_output("p5_only", z_reg, v_reg, 3'b101, 1'b1);

        apply_stimulus(8'b0100_1011);
        #1;
        check_output("hold_between_edges", z_reg, v_reg, 3'b101, 1'b1);
        step();
        check_output("prio_0100_1011", z_reg, v_reg, 3'b110, 1'b1);

        apply_stimulus(8'b0000_0001);
        step();
        check_output("p0_only", z_reg, v_reg, 3'b000, 1'b1);

        apply_stimulus(8'b0000_0000);
        step();
        check_output("all_zero", z_reg, v_reg, 3'b000, 1'b0);

        // Exhaustive sweep. The expected index is the position of the highest set bit, found by an ascending scan.
        for (int n = 0; n < 256; n++) begin
            logic [7:0] vec;
            vec   = n[7:0];
            exp_z = 3'd0;
            exp_v = 1'b0;
            for (int b = 0; b < 8; b++) begin
                if (vec[b]) begin
                    exp_z = b[2:0];
                    exp_v = 1'b1;
                end
            end
            apply_stimulus(vec);
            #1;
            check_output($sformatf("sweep_cmb_%0d", n), z_cmb, v_cmb, exp_z, exp_v);
            step();
            check_output($sformatf("sweep_reg_%0d", n), z_reg, v_reg, exp_z, exp_v);
        end

        // Mid-stream reset: assert rst between edges, hold it, then release it.
        apply_stimulus(8'b1000_0000);
        step();
        check_output("p7_only", z_reg, v_reg, 3'b111, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_output("async_reset_immediate", z_reg, v_reg, 3'b000, 1'b0);
        step();
        check_output("reset_held", z_reg, v_reg, 3'b000, 1'b0);
        apply_stimulus(8'b0001_0000);
        rst = 1'b0;
        #1;
        check_output("no_stale_after_release", z_reg, v_reg, 3'b000, 1'b0);
        step();
        check_output("resume_p4", z_reg, v_reg, 3'b100, 1'b1);

        // The combinational instance responds in the same timestep, without a clock edge.
        #1;
        req = 8'b0010_0110;
        #0;
        #1;
        check_output("cmb_0010_0110", z_cmb, v_cmb, 3'b101, 1'b1);
        check_output("reg_unchanged_midcycle", z_reg, v_reg, 3'b100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
